// File: rtl/abc_pulse_gen_if.sv
// Pulse-generator control/observation bundle: run controls and counts in,
// detector lines and run status out.
interface abc_pulse_gen_if #(
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
);
  logic             enable;
  logic             start;
  logic [CNT_W-1:0] n_a;
  logic [CNT_W-1:0] n_b;
  logic [CNT_W-1:0] n_c;
  logic [GAP_W-1:0] gap;
  logic             X1;
  logic             X2;
  logic             busy;
  logic             done;

  modport master (
    output enable, start, n_a, n_b, n_c, gap,
    input  X1, X2, busy, done
  );

  modport slave (
    input  enable, start, n_a, n_b, n_c, gap,
    output X1, X2, busy, done
  );
endinterface

// File: rtl/abc_pulse_gen.sv
// Programmable A-only / B-only / coincident pulse source driving the X1/X2
// detector lines, with a fixed low gap after every pulse.
module abc_pulse_gen #(
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  abc_pulse_gen_if.slave   io_bus
);

  // state    | meaning
  // S_IDLE   | waiting for start with enable high
  // S_EMIT_A | emitting A-only slots (X1=0, X2=1)
  // S_EMIT_B | emitting B-only slots (X1=1, X2=0)
  // S_EMIT_C | emitting coincident slots (X1=1, X2=1)
  // S_DONE   | single completion cycle, done strobe high
  typedef enum logic [2:0] {
    S_IDLE, S_EMIT_A, S_EMIT_B, S_EMIT_C, S_DONE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt_a;
  logic [CNT_W-1:0] r_cnt_b;
  logic [CNT_W-1:0] r_cnt_c;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] r_tmr;
  logic             r_x1;
  logic             r_x2;
  logic             r_busy;
  logic             r_done;

  logic             w_slot_end;
  logic             w_last;
  state_t           w_entry;
  state_t           w_after;
  logic [CNT_W-1:0] w_cur_cnt;

  function automatic state_t f_pick(input logic ha, input logic hb, input logic hc);
    if (ha) return S_EMIT_A;
    if (hb) return S_EMIT_B;
    if (hc) return S_EMIT_C;
    return S_DONE;
  endfunction

  function automatic logic [1:0] f_pat(input state_t s);
    case (s)
      S_EMIT_A: return 2'b01;
      S_EMIT_B: return 2'b10;
      S_EMIT_C: return 2'b11;
      default:  return 2'b00;
    endcase
  endfunction

  // Phases with a zero count are skipped by jumping straight past them.
  assign w_entry    = f_pick(io_bus.n_a != '0, io_bus.n_b != '0, io_bus.n_c != '0);
  assign w_slot_end = (r_tmr == r_gap);
  assign w_last     = (w_cur_cnt == CNT_W'(1));

  always_comb begin
    w_after   = S_DONE;
    w_cur_cnt = '0;
    case (r_state)
      S_EMIT_A: begin
        w_after   = f_pick(1'b0, r_cnt_b != '0, r_cnt_c != '0);
        w_cur_cnt = r_cnt_a;
      end
      S_EMIT_B: begin
        w_after   = f_pick(1'b0, 1'b0, r_cnt_c != '0);
        w_cur_cnt = r_cnt_b;
      end
      S_EMIT_C: begin
        w_after   = S_DONE;
        w_cur_cnt = r_cnt_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
      r_cnt_c <= '0;
      r_gap   <= '0;
      r_tmr   <= '0;
      r_x1    <= 1'b0;
      r_x2    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (io_bus.enable) begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            r_cnt_a       <= io_bus.n_a;
            r_cnt_b       <= io_bus.n_b;
            r_cnt_c       <= io_bus.n_c;
            r_gap         <= io_bus.gap;
            r_tmr         <= '0;
            r_state       <= w_entry;
            {r_x1, r_x2}  <= f_pat(w_entry);
            r_busy        <= 1'b1;
            r_done        <= (w_entry == S_DONE);
          end
        end
        S_EMIT_A, S_EMIT_B, S_EMIT_C: begin
          if (w_slot_end) begin
            r_tmr <= '0;
            case (r_state)
              S_EMIT_A: r_cnt_a <= r_cnt_a - CNT_W'(1);
              S_EMIT_B: r_cnt_b <= r_cnt_b - CNT_W'(1);
              S_EMIT_C: r_cnt_c <= r_cnt_c - CNT_W'(1);
              default: ;
            endcase
            if (w_last) begin
              r_state      <= w_after;
              {r_x1, r_x2} <= f_pat(w_after);
              r_done       <= (w_after == S_DONE);
            end else begin
              {r_x1, r_x2} <= f_pat(r_state);
            end
          end else begin
            r_tmr        <= r_tmr + GAP_W'(1);
            {r_x1, r_x2} <= 2'b00;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Gating instead of clearing keeps a held pulse cycle alive until enable returns.
  assign io_bus.X1   = r_x1 & io_bus.enable;
  assign io_bus.X2   = r_x2 & io_bus.enable;
  assign io_bus.busy = r_busy;
  assign io_bus.done = r_done;

endmodule

// File: tb/tb_abc_pulse_gen.sv
// Bench for abc_pulse_gen: table-driven runs, hand-written corner sequences,
// and a cycle-by-cycle queue-based reference model over random stimulus.
module tb_abc_pulse_gen;
  localparam int CNT_W = 4;
  localparam int GAP_W = 4;

  logic clk = 1'b0;
  logic reset;

  abc_pulse_gen_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

  abc_pulse_gen #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: a started run is expanded into the exact list of
  // per-cycle observations it must produce; each enabled edge consumes one.
  typedef struct packed {
    logic x1;
    logic x2;
    logic busy;
    logic done;
  } obs_t;

  obs_t mq[$];
  obs_t mcur = '0;
  bit   mdl_on = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      mcur = '0;
    end else if (bus.enable) begin
      if (mq.size() > 0) mcur = mq.pop_front();
      else if (mcur.busy) mcur = '0;
      else if (bus.start) begin
        int cnt [3];
        cnt[0] = int'(bus.n_a);
        cnt[1] = int'(bus.n_b);
        cnt[2] = int'(bus.n_c);
        for (int c = 0; c < 3; c++) begin
          for (int i = 0; i < cnt[c]; i++) begin
            mq.push_back('{x1: (c != 0), x2: (c != 1), busy: 1'b1, done: 1'b0});
            for (int g = 0; g < int'(bus.gap); g++)
              mq.push_back('{x1: 1'b0, x2: 1'b0, busy: 1'b1, done: 1'b0});
          end
        end
        mq.push_back('{x1: 1'b0, x2: 1'b0, busy: 1'b1, done: 1'b1});
        mcur = mq.pop_front();
      end
    end
  end

  always @(negedge clk) begin
    if (mdl_on)
      chk("model_cycle", int'({bus.X1, bus.X2, bus.busy, bus.done}),
          int'({mcur.x1 & bus.enable, mcur.x2 & bus.enable, mcur.busy, mcur.done}));
  end

  int pa, pb, pc, done_c, done_n, quiet_bad;
  int busy_at [4];
  int rst_obs;

  // mode: 0 plain, 4 enable held low in cycles 4-8, 5 extra starts at 3 and 19,
  // 6 reset during cycle 8. Cycle numbers are relative to the start edge.
  task automatic run(input int na, input int nb, input int nc, input int gp,
                     input int mode, input int ncyc);
    @(posedge clk); #1;
    bus.n_a = CNT_W'(na); bus.n_b = CNT_W'(nb); bus.n_c = CNT_W'(nc);
    bus.gap = GAP_W'(gp); bus.start = 1'b1; bus.enable = 1'b1;
    pa = 0; pb = 0; pc = 0; done_c = -1; done_n = 0; quiet_bad = 0; rst_obs = -1;
    for (int i = 0; i < 4; i++) busy_at[i] = -1;
    for (int rel = 1; rel <= ncyc; rel++) begin
      @(posedge clk); #1;
      bus.start  = (mode == 5) && (rel == 3 || rel == 19);
      bus.n_a    = CNT_W'($urandom);
      bus.n_b    = CNT_W'($urandom);
      bus.n_c    = CNT_W'($urandom);
      bus.gap    = GAP_W'($urandom);
      bus.enable = !(mode == 4 && rel >= 4 && rel <= 8);
      reset      = (mode == 6 && rel == 8);
      @(negedge clk);
      if (!bus.X1 &&  bus.X2) pa++;
      if ( bus.X1 && !bus.X2) pb++;
      if ( bus.X1 &&  bus.X2) pc++;
      if (bus.done) begin
        done_n++;
        if (done_c < 0) done_c = rel;
      end
      if (rel <= 3) busy_at[rel] = int'(bus.busy);
      if (mode == 4 && rel >= 4 && rel <= 8 && (bus.X1 || bus.X2)) quiet_bad++;
      if (mode == 6 && rel == 9) rst_obs = int'({bus.X1, bus.X2, bus.busy, bus.done});
    end
    bus.start = 1'b0; reset = 1'b0; bus.enable = 1'b1;
  endtask

  typedef struct {
    int na, nb, nc, gp;
    int exp_done;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{3, 2, 1, 2, 19};
    vecs[1] = '{15, 0, 15, 0, 31};
    vecs[2] = '{0, 0, 0, 3, 1};
    vecs[3] = '{0, 4, 0, 15, 65};
    vecs[4] = '{1, 1, 1, 0, 4};
    vecs[5] = '{0, 0, 2, 1, 5};
    vecs[6] = '{7, 0, 0, 1, 15};

    reset = 1'b1; bus.enable = 1'b1; bus.start = 1'b0;
    bus.n_a = '0; bus.n_b = '0; bus.n_c = '0; bus.gap = '0;
    repeat (3) @(posedge clk);
    mdl_on = 1'b1;
    @(negedge clk);
    chk("reset_state", int'({bus.X1, bus.X2, bus.busy, bus.done}), 0);
    @(posedge clk); #1 reset = 1'b0;

    foreach (vecs[k]) begin
      run(vecs[k].na, vecs[k].nb, vecs[k].nc, vecs[k].gp, 0, vecs[k].exp_done + 3);
      chk($sformatf("v%0d_a", k), pa, vecs[k].na);
      chk($sformatf("v%0d_b", k), pb, vecs[k].nb);
      chk($sformatf("v%0d_c", k), pc, vecs[k].nc);
      chk($sformatf("v%0d_done_cycle", k), done_c, vecs[k].exp_done);
      chk($sformatf("v%0d_done_count", k), done_n, 1);
    end

    run(0, 0, 0, 0, 0, 4);
    chk("zero_busy_c1", busy_at[1], 1);
    chk("zero_busy_c2", busy_at[2], 0);
    chk("zero_done_c1", done_c, 1);

    run(3, 2, 1, 2, 4, 27);
    chk("hold_quiet", quiet_bad, 0);
    chk("hold_done_cycle", done_c, 24);
    chk("hold_a", pa, 3);
    chk("hold_b", pb, 2);
    chk("hold_c", pc, 1);

    run(3, 2, 1, 2, 5, 22);
    chk("restart_done_cycle", done_c, 19);
    chk("restart_done_count", done_n, 1);
    chk("restart_abc", pa * 100 + pb * 10 + pc, 321);

    run(3, 2, 1, 2, 6, 10);
    chk("abort_outputs", rst_obs, 0);
    chk("abort_no_done", done_n, 0);
    run(2, 1, 3, 1, 0, 16);
    chk("fresh_done_cycle", done_c, 13);
    chk("fresh_abc", pa * 100 + pb * 10 + pc, 213);

    for (int k = 0; k < 4000; k++) begin
      @(posedge clk); #1;
      bus.enable = ($urandom_range(0, 9) != 0);
      bus.start  = ($urandom_range(0, 5) == 0);
      reset      = ($urandom_range(0, 299) == 0);
      bus.n_a    = CNT_W'($urandom_range(0, 5));
      bus.n_b    = CNT_W'($urandom_range(0, 5));
      bus.n_c    = CNT_W'($urandom_range(0, 5));
      bus.gap    = GAP_W'(($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3));
    end
    @(posedge clk); #1;
    reset = 1'b0; bus.start = 1'b0; bus.enable = 1'b1;
    @(negedge clk);
    mdl_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
